// File: rtl/bcd_countdown_5digit_if.sv
// bcd_countdown_5digit_if
// Control and status bundle for the 5-digit BCD down-counter.
//   master : drives load/load_value/start/pause/tick, observes status
//   slave  : the counter itself; drives count/running/zero/done/load_err
interface bcd_countdown_5digit_if;
  logic        load;
  logic [19:0] load_value;
  logic        start;
  logic        pause;
  logic        tick;
  logic [19:0] count;
  logic        running;
  logic        zero;
  logic        done;
  logic        load_err;

  modport master (
    output load, load_value, start, pause, tick,
    input  count, running, zero, done, load_err
  );

  modport slave (
    input  load, load_value, start, pause, tick,
    output count, running, zero, done, load_err
  );
endinterface

// File: rtl/bcd_countdown_5digit.sv
// bcd_countdown_5digit
// Five-digit packed-BCD down-counter (00000-99999) with load/start/pause
// control. Each qualified tick in RUN decrements by one through a digit-wise
// borrow chain; reaching 00000 pulses done for one cycle.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bcd_countdown_5digit_if.slave
//           in : load, load_value[19:0], start, pause, tick
//           out: count[19:0], running, zero, done, load_err (all registered)
//
// Optional feature: define BCD_COUNTDOWN_RELOAD_EN for auto-reload on expiry.
//
// Input priority: reset > load > pause > start > tick.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | loaded or reset, waiting for start
// RUN     | counting down on tick
// HOLD    | paused, count frozen, start resumes
// EXPIRED | reached zero, only load or reset leaves
module bcd_countdown_5digit (
  input  logic                        clk,
  input  logic                        reset,
  bcd_countdown_5digit_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] count_q, count_d;
  logic        running_q;
  logic        zero_q;
  logic        done_q, done_d;
  logic        load_err_q, load_err_d;
  logic [19:0] clamped;
  logic        clamp_hit;
`ifdef BCD_COUNTDOWN_RELOAD_EN
  logic [19:0] reload_q, reload_d;
`endif

  // Borrow ripples from the least significant digit until a nonzero digit
  // absorbs it; callers guarantee v != 0 so there is no underflow.
  function automatic logic [19:0] bcd_dec(input logic [19:0] v);
    logic [19:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    clamped   = bus.load_value;
    clamp_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.load_value[i*4 +: 4] > 4'd9) begin
        clamped[i*4 +: 4] = 4'd9;
        clamp_hit         = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef BCD_COUNTDOWN_RELOAD_EN
    reload_d   = reload_q;
`endif
    if (bus.load) begin
      count_d    = clamped;
      load_err_d = clamp_hit;
      state_d    = IDLE;
`ifdef BCD_COUNTDOWN_RELOAD_EN
      reload_d   = clamped;
`endif
    end else if (bus.pause) begin
      if (state_q == RUN) state_d = HOLD;
    end else if (bus.start) begin
      if (state_q == IDLE || state_q == HOLD) begin
        if (count_q == 20'h0) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end else if (bus.tick && state_q == RUN && count_q != 20'h0) begin
      if (count_q == 20'h00001) begin
        done_d  = 1'b1;
`ifdef BCD_COUNTDOWN_RELOAD_EN
        if (reload_q != 20'h0) begin
          count_d = reload_q;
        end else begin
          count_d = 20'h0;
          state_d = EXPIRED;
        end
`else
        count_d = 20'h0;
        state_d = EXPIRED;
`endif
      end else begin
        count_d = bcd_dec(count_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 20'h0;
      running_q  <= 1'b0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef BCD_COUNTDOWN_RELOAD_EN
      reload_q   <= 20'h0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      // running/zero are derived from next-state values so they line up
      // with the registered count and state.
      running_q  <= (state_d == RUN);
      zero_q     <= (count_d == 20'h0);
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef BCD_COUNTDOWN_RELOAD_EN
      reload_q   <= reload_d;
`endif
    end
  end

  assign bus.count    = count_q;
  assign bus.running  = running_q;
  assign bus.zero     = zero_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule
